// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing signal controller downstream of the one-hot traffic light bus.
// Latency: all outputs registered; a grant on a RED edge shows walk=1 the following cycle.
// Backpressure: none; light and ped_req are sampled every cycle and never stalled.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous reset, active-low
//   light       one-hot light state (RED 100, YELLOW 010, GREEN 001)
//   ped_req     pedestrian request, pulse or level
//   walk        WALK lamp
//   dont_walk   DON'T WALK lamp, solid or flashing during clearance
//   req_pending request latched, waiting for the next RED phase start
//   countdown   remaining clearance cycles during CLEAR, else 0
//   light_err   light bus was not exactly one-hot on the previous cycle
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       light,
  input  logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic             light_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [2:0]       RED        = 3'b100;
  localparam logic [2:0]       YELLOW     = 3'b010;
  localparam logic [2:0]       GREEN      = 3'b001;
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] walk_cnt, walk_cnt_n;
  logic [CNT_W-1:0] countdown_n;
  logic [2:0]       prev_light;
  logic             walk_n, dont_walk_n, req_pending_n, light_err_n;

  logic is_red, illegal, red_edge;

  assign is_red   = (light == RED);
  assign illegal  = !((light == RED) || (light == YELLOW) || (light == GREEN));
  // prev_light follows every value, illegal ones included, so RED after a
  // glitch or after YELLOW both count as the start of a RED phase.
  assign red_edge = is_red && (prev_light != RED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      walk_cnt    <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      countdown   <= '0;
      light_err   <= 1'b0;
      prev_light  <= RED;
    end else begin
      state       <= state_n;
      walk_cnt    <= walk_cnt_n;
      walk        <= walk_n;
      dont_walk   <= dont_walk_n;
      req_pending <= req_pending_n;
      countdown   <= countdown_n;
      light_err   <= light_err_n;
      prev_light  <= light;
    end
  end

  always_comb begin
    state_n       = state;
    walk_cnt_n    = walk_cnt;
    walk_n        = walk;
    dont_walk_n   = dont_walk;
    req_pending_n = req_pending;
    countdown_n   = countdown;
    light_err_n   = illegal;

    if (illegal) begin
      // A corrupt bus wipes any request, including one arriving this cycle.
      state_n       = IDLE;
      walk_cnt_n    = '0;
      walk_n        = 1'b0;
      dont_walk_n   = 1'b1;
      countdown_n   = '0;
      req_pending_n = 1'b0;
    end else begin
      if (ped_req) begin
        req_pending_n = 1'b1;
      end

      unique case (state)
        IDLE: begin
          walk_n      = 1'b0;
          dont_walk_n = 1'b1;
          countdown_n = '0;
          if (red_edge && (req_pending || ped_req)) begin
            state_n       = WALK;
            walk_n        = 1'b1;
            dont_walk_n   = 1'b0;
            walk_cnt_n    = WALK_LOAD;
            req_pending_n = 1'b0;
          end
        end

        WALK: begin
          if (!is_red) begin
            // Safety abort: RED ended under a walking pedestrian.
            state_n     = IDLE;
            walk_n      = 1'b0;
            dont_walk_n = 1'b1;
            countdown_n = '0;
            walk_cnt_n  = '0;
          end else if (walk_cnt <= CNT_ONE) begin
            state_n     = CLEAR;
            walk_n      = 1'b0;
            dont_walk_n = 1'b1;
            countdown_n = FLASH_LOAD;
            walk_cnt_n  = '0;
          end else begin
            walk_cnt_n = walk_cnt - CNT_ONE;
          end
        end

        CLEAR: begin
          if (!is_red || (countdown <= CNT_ONE)) begin
            state_n     = IDLE;
            walk_n      = 1'b0;
            dont_walk_n = 1'b1;
            countdown_n = '0;
          end else begin
            countdown_n = countdown - CNT_ONE;
            dont_walk_n = ~dont_walk;
          end
        end

        default: begin
          state_n     = IDLE;
          walk_n      = 1'b0;
          dont_walk_n = 1'b1;
          countdown_n = '0;
          walk_cnt_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl with the default parameters (8 walk, 6 clear).
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Each check is an immediate assertion that counts and reports a failure.
module tb_ped_signal_ctrl;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] BAD = 3'b011;
  localparam logic [2:0] OFF = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light;
  logic       ped_req;
  logic       walk, dont_walk, req_pending, light_err;
  logic [3:0] countdown;

  int n_assert = 0;
  int n_fail   = 0;

  ped_signal_ctrl #(.WALK_CYCLES(8), .FLASH_CYCLES(6), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .light      (light),
    .ped_req    (ped_req),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .countdown  (countdown),
    .light_err  (light_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Solid DON'T WALK with no countdown.
  task automatic chk_idle(input string tag);
    chk({tag, ".walk"}, 32'(walk), 32'd0);
    chk({tag, ".dont_walk"}, 32'(dont_walk), 32'd1);
    chk({tag, ".countdown"}, 32'(countdown), 32'd0);
  endtask

  initial begin
    // Reset held two cycles while RED.
    reset = 1'b0; light = R; ped_req = 1'b0;
    step(); step();
    chk_idle("rst");
    chk("rst.req_pending", 32'(req_pending), 32'd0);
    chk("rst.light_err", 32'(light_err), 32'd0);

    // Release while RED with a request: not a RED edge, so only latched.
    reset = 1'b1; ped_req = 1'b1;
    step();
    chk("rel.walk", 32'(walk), 32'd0);
    chk("rel.req_pending", 32'(req_pending), 32'd1);
    ped_req = 1'b0;

    // Basic grant: request during GREEN, then GREEN->YELLOW->RED.
    light = G; step();
    ped_req = 1'b1; step();
    chk("grn.req_pending", 32'(req_pending), 32'd1);
    ped_req = 1'b0; step();
    light = Y; step();
    chk("yel.walk", 32'(walk), 32'd0);
    chk("yel.req_pending", 32'(req_pending), 32'd1);
    light = R; step();
    chk("w1.walk", 32'(walk), 32'd1);
    chk("w1.dont_walk", 32'(dont_walk), 32'd0);
    chk("w1.req_pending", 32'(req_pending), 32'd0);
    chk("w1.countdown", 32'(countdown), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk($sformatf("w%0d.walk", i), 32'(walk), 32'd1);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("clr%0d.walk", k), 32'(walk), 32'd0);
      chk($sformatf("clr%0d.dont_walk", k), 32'(dont_walk), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("clr%0d.countdown", k), 32'(countdown), 32'(6 - k));
    end
    step();
    chk_idle("post");
    chk("post.req_pending", 32'(req_pending), 32'd0);
    step();
    chk_idle("post2");

    // Same-cycle request on the RED edge, then abort on WALK cycle 3.
    light = G; step();
    light = R; ped_req = 1'b1; step();
    chk("sc.walk", 32'(walk), 32'd1);
    chk("sc.req_pending", 32'(req_pending), 32'd0);
    ped_req = 1'b0; step();
    chk("sc2.walk", 32'(walk), 32'd1);
    chk("sc2.req_pending", 32'(req_pending), 32'd0);
    step();
    chk("sc3.walk", 32'(walk), 32'd1);
    light = G; step();
    chk_idle("abort");
    chk("abort.req_pending", 32'(req_pending), 32'd0);

    // Request during WALK is held through CLEAR and the rest of RED.
    light = R; ped_req = 1'b1; step();
    chk("rw1.walk", 32'(walk), 32'd1);
    ped_req = 1'b0; step();
    ped_req = 1'b1; step();
    chk("rw3.walk", 32'(walk), 32'd1);
    chk("rw3.req_pending", 32'(req_pending), 32'd1);
    ped_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rwclr.countdown", 32'(countdown), 32'd6);
    chk("rwclr.req_pending", 32'(req_pending), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("rwlast.countdown", 32'(countdown), 32'd1);
    step();
    chk_idle("rwidle");
    chk("rwidle.req_pending", 32'(req_pending), 32'd1);
    step(); step();
    chk("rwred.walk", 32'(walk), 32'd0);
    chk("rwred.req_pending", 32'(req_pending), 32'd1);
    light = G; step();
    light = R; step();
    chk("rwnext.walk", 32'(walk), 32'd1);
    chk("rwnext.req_pending", 32'(req_pending), 32'd0);
    light = G; step();
    chk_idle("rwabort");

    // Illegal bus for two cycles with a pending request.
    ped_req = 1'b1; step();
    chk("ill.pre_pending", 32'(req_pending), 32'd1);
    light = BAD; step();
    chk("ill1.light_err", 32'(light_err), 32'd1);
    chk("ill1.req_pending", 32'(req_pending), 32'd0);
    ped_req = 1'b0; step();
    chk("ill2.light_err", 32'(light_err), 32'd1);
    chk_idle("ill2");
    light = R; ped_req = 1'b1; step();
    chk("illr.light_err", 32'(light_err), 32'd0);
    chk("illr.walk", 32'(walk), 32'd1);
    chk("illr.req_pending", 32'(req_pending), 32'd0);

    // All-dark bus mid-WALK forces IDLE; returning RED is an edge but nothing is pending.
    ped_req = 1'b0; light = OFF; step();
    chk("off.light_err", 32'(light_err), 32'd1);
    chk_idle("off");
    light = R; step();
    chk("offr.light_err", 32'(light_err), 32'd0);
    chk("offr.walk", 32'(walk), 32'd0);

    // Reset mid-WALK drops a request arriving on the same edge.
    light = G; step();
    light = R; ped_req = 1'b1; step();
    chk("rw.walk", 32'(walk), 32'd1);
    reset = 1'b0; step();
    chk_idle("rmid");
    chk("rmid.req_pending", 32'(req_pending), 32'd0);
    reset = 1'b1; ped_req = 1'b0; step();
    chk("rrel.walk", 32'(walk), 32'd0);
    chk("rrel.req_pending", 32'(req_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
